// File: rtl/fifo_shift_round_pkg.sv
// Shared sizing helpers and direction codes for the fifo_shift_round width converter.
package fifo_shift_round_pkg;

  localparam logic [1:0] UP   = 2'd0;
  localparam logic [1:0] DOWN = 2'd1;
  localparam logic [1:0] PASS = 2'd2;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_shift_round_oreg.sv
// One-entry valid/ready output register; refills whenever empty or being drained.
module fifo_shift_round_oreg
  import fifo_shift_round_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [Width-1:0] inData_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  output logic [Width-1:0] outData_o,
  output logic             outValid_o,
  input  logic             outReady_i
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign inReady_o  = !valid_q || outReady_i;
  assign outData_o  = data_q;
  assign outValid_o = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (inReady_o) begin
      valid_d = inValid_i;
      if (inValid_i) data_d = inData_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fifo_shift_round.sv
// Streaming width converter: packs narrow words into a wide word or unpacks a wide word
// into narrow chunks (little-endian, zero-padded to a whole number of chunks).
module fifo_shift_round
  import fifo_shift_round_pkg::*;
#(
  parameter int IWidth   = 64,
  parameter int OWidth   = 512,
  parameter int Register = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [IWidth-1:0] inData_i,
  input  logic              inValid_i,
  output logic              inAccept_o,
  output logic [OWidth-1:0] outData_o,
  output logic              outValid_o,
  input  logic              outReady_i
);

  localparam int N    = (IWidth < OWidth) ? IWidth : OWidth;
  localparam int W    = (IWidth < OWidth) ? OWidth : IWidth;
  localparam int R    = ceil_div(W, N);
  localparam int BufW = R * N;
  localparam int CntW = clog2(R + 1);
  localparam logic [1:0] Dir = (IWidth < OWidth) ? UP : ((IWidth > OWidth) ? DOWN : PASS);
  localparam logic [CntW-1:0] RCnt = CntW'(R);

  logic [BufW-1:0]   shiftBuf_q, shiftBuf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              coreValid, coreReady, drain, inFire;
  logic [OWidth-1:0] coreData;

  assign drain  = coreValid && coreReady;
  assign inFire = inValid_i && inAccept_o;

  generate
    if (Dir == UP) begin : gUp
      logic [CntW-1:0] slot;
      int              slotBase;

      assign coreValid = (cnt_q == RCnt);
      assign coreData  = shiftBuf_q[OWidth-1:0];

      // A word arriving while the full buffer drains starts the next word at slot 0.
      always_comb begin
        shiftBuf_d = shiftBuf_q;
        cnt_d      = cnt_q;
        inAccept_o = (cnt_q < RCnt) || drain;
        slot       = drain ? '0 : cnt_q;
        slotBase   = int'(slot) * N;
        if (drain) cnt_d = '0;
        if (inFire) begin
          shiftBuf_d[slotBase +: N] = inData_i;
          cnt_d = slot + CntW'(1);
        end
      end
    end else begin : gDown
      assign coreValid = (cnt_q != '0);
      assign coreData  = shiftBuf_q[N-1:0];

      // Reload may coincide with taking the final chunk of the previous word.
      always_comb begin
        shiftBuf_d = shiftBuf_q;
        cnt_d      = cnt_q;
        inAccept_o = (cnt_q == '0) || ((cnt_q == CntW'(1)) && drain);
        if (inFire) begin
          shiftBuf_d = BufW'(inData_i);
          cnt_d      = RCnt;
        end else if (drain) begin
          shiftBuf_d = shiftBuf_q >> N;
          cnt_d      = cnt_q - CntW'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      shiftBuf_q <= '0;
      cnt_q      <= '0;
    end else begin
      shiftBuf_q <= shiftBuf_d;
      cnt_q      <= cnt_d;
    end
  end

  generate
    if (Register != 0) begin : gReg
      fifo_shift_round_oreg #(
        .Width(OWidth)
      ) uOreg (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .inData_i  (coreData),
        .inValid_i (coreValid),
        .inReady_o (coreReady),
        .outData_o (outData_o),
        .outValid_o(outValid_o),
        .outReady_i(outReady_i)
      );
    end else begin : gWire
      assign outData_o  = coreData;
      assign outValid_o = coreValid;
      assign coreReady  = outReady_i;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_shift_round.sv
// Exercises five converter configurations against a queue-based reference model,
// with directed timing scenarios followed by randomized valid/ready traffic.
module tb_fifo_shift_round;

  localparam int NI = 5;
  // 0: 64->512 reg, 1: 24->8, 2: 20->8 reg, 3: 64->64 reg, 4: 8->20
  localparam int InWidths  [0:NI-1] = '{64, 24, 20, 64, 8};
  localparam int OutWidths [0:NI-1] = '{512, 8, 8, 64, 20};

  localparam bit         DnValid [0:4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit         DnAcc   [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [7:0] DnData  [0:4] = '{8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h00};
  localparam bit         RdValid [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] RdData  [0:6] = '{8'h00, 8'h00, 8'hDE, 8'hBC, 8'h0A, 8'h00, 8'h00};
  localparam bit         BpValid [0:9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [7:0] BpData  [0:9] = '{8'h00, 8'h56, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h12, 8'h00};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic inValid [NI];
  logic inAccept [NI];
  logic outValid [NI];
  logic outReady [NI];

  logic [63:0]  in0;  logic [511:0] out0;
  logic [23:0]  in1;  logic [7:0]   out1;
  logic [19:0]  in2;  logic [7:0]   out2;
  logic [63:0]  in3;  logic [63:0]  out3;
  logic [7:0]   in4;  logic [19:0]  out4;

  fifo_shift_round #(.IWidth(64), .OWidth(512), .Register(1)) uUp (
    .clock_i(clock), .reset_i(reset), .inData_i(in0), .inValid_i(inValid[0]), .inAccept_o(inAccept[0]),
    .outData_o(out0), .outValid_o(outValid[0]), .outReady_i(outReady[0]));
  fifo_shift_round #(.IWidth(24), .OWidth(8), .Register(0)) uDown (
    .clock_i(clock), .reset_i(reset), .inData_i(in1), .inValid_i(inValid[1]), .inAccept_o(inAccept[1]),
    .outData_o(out1), .outValid_o(outValid[1]), .outReady_i(outReady[1]));
  fifo_shift_round #(.IWidth(20), .OWidth(8), .Register(1)) uRound (
    .clock_i(clock), .reset_i(reset), .inData_i(in2), .inValid_i(inValid[2]), .inAccept_o(inAccept[2]),
    .outData_o(out2), .outValid_o(outValid[2]), .outReady_i(outReady[2]));
  fifo_shift_round #(.IWidth(64), .OWidth(64), .Register(1)) uEqual (
    .clock_i(clock), .reset_i(reset), .inData_i(in3), .inValid_i(inValid[3]), .inAccept_o(inAccept[3]),
    .outData_o(out3), .outValid_o(outValid[3]), .outReady_i(outReady[3]));
  fifo_shift_round #(.IWidth(8), .OWidth(20), .Register(0)) uUpRound (
    .clock_i(clock), .reset_i(reset), .inData_i(in4), .inValid_i(inValid[4]), .inAccept_o(inAccept[4]),
    .outData_o(out4), .outValid_o(outValid[4]), .outReady_i(outReady[4]));

  int checks;
  int failures;
  logic [511:0] expQ [NI][$];
  logic [511:0] acc [NI];
  int accCnt [NI];
  int outCount [NI];
  logic inFireS [NI];
  logic outValidS [NI];
  logic inAcceptS [NI];
  logic [511:0] outDataS [NI];

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] maskBits(input int w);
    logic [511:0] m;
    m = '0;
    for (int b = 0; b < w; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic setInData(input int idx, input logic [63:0] v);
    case (idx)
      0: in0 = v;
      1: in1 = v[23:0];
      2: in2 = v[19:0];
      3: in3 = v;
      default: in4 = v[7:0];
    endcase
  endtask

  function automatic logic [63:0] getIn(input int idx);
    case (idx)
      0: return in0;
      1: return 64'(in1);
      2: return 64'(in2);
      3: return in3;
      default: return 64'(in4);
    endcase
  endfunction

  function automatic logic [511:0] getOut(input int idx);
    case (idx)
      0: return out0;
      1: return 512'(out1);
      2: return 512'(out2);
      3: return 512'(out3);
      default: return 512'(out4);
    endcase
  endfunction

  // Reference: packing gathers ceil(O/I) words little-endian; unpacking emits ceil(I/O) chunks.
  task automatic modelAccept(input int idx, input logic [63:0] w);
    int iw;
    int ow;
    logic [511:0] wx;
    iw = InWidths[idx];
    ow = OutWidths[idx];
    wx = 512'(w) & maskBits(iw);
    if (iw < ow) begin
      acc[idx] = acc[idx] | (wx << (accCnt[idx] * iw));
      accCnt[idx]++;
      if (accCnt[idx] == (ow + iw - 1) / iw) begin
        expQ[idx].push_back(acc[idx] & maskBits(ow));
        acc[idx] = '0;
        accCnt[idx] = 0;
      end
    end else begin
      for (int k = 0; k < (iw + ow - 1) / ow; k++)
        expQ[idx].push_back((wx >> (k * ow)) & maskBits(ow));
    end
  endtask

  task automatic modelOutput(input int idx, input logic [511:0] obs);
    if (expQ[idx].size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL out%0d: got unexpected word %0h expected none", idx, obs);
    end else begin
      checkOutput($sformatf("out%0d", idx), obs, expQ[idx].pop_front());
    end
  endtask

  // Sample handshakes on the falling edge, then advance just past the next rising edge.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      inFireS[i]   = inValid[i] && inAccept[i];
      outValidS[i] = outValid[i];
      inAcceptS[i] = inAccept[i];
      outDataS[i]  = getOut(i);
      if (reset) begin
        expQ[i].delete();
        acc[i] = '0;
        accCnt[i] = 0;
        inFireS[i] = 1'b0;
      end else begin
        if (inFireS[i]) modelAccept(i, getIn(i));
        if (outValid[i] && outReady[i]) begin
          outCount[i]++;
          modelOutput(i, outDataS[i]);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleAll();
    for (int i = 0; i < NI; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b1;
    end
  endtask

  // Random traffic; a presented word is held until it is accepted.
  task automatic applyStimulus(input int idx);
    if (!inValid[idx] || inFireS[idx]) begin
      inValid[idx] = ($urandom_range(0, 3) != 0);
      setInData(idx, {$urandom, $urandom});
    end
    outReady[idx] = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int pulses;
    int firstCycle;
    int guard;
    logic [511:0] expWord;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      inValid[i] = 1'b0;
      outReady[i] = 1'b0;
      setInData(i, 64'd0);
      acc[i] = '0;
      accCnt[i] = 0;
      outCount[i] = 0;
      inFireS[i] = 1'b0;
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("rstValid%0d", i), outValidS[i], 0);
      checkOutput($sformatf("rstData%0d", i), outDataS[i], 0);
      checkOutput($sformatf("rstAccept%0d", i), inAcceptS[i], 1);
    end

    // Upsize 64->512 with output register, consumer always ready.
    pulses = 0;
    firstCycle = -1;
    expWord = '0;
    for (int k = 0; k < 8; k++) expWord = expWord | (512'(k) << (k * 64));
    for (int c = 0; c < 15; c++) begin
      idleAll();
      if (c < 8) begin
        inValid[0] = 1'b1;
        setInData(0, 64'(c));
      end
      tick();
      if (c < 8) checkOutput($sformatf("upAccept c%0d", c), inAcceptS[0], 1);
      if (outValidS[0]) begin
        pulses++;
        if (firstCycle < 0) begin
          firstCycle = c;
          checkOutput("upData", outDataS[0], expWord);
        end
      end
    end
    checkOutput("upPulses", pulses, 1);
    checkOutput("upLatency", firstCycle, 9);

    // Downsize 24->8 without register.
    for (int c = 0; c < 5; c++) begin
      idleAll();
      if (c == 0) begin
        inValid[1] = 1'b1;
        setInData(1, 64'hABCDEF);
      end
      tick();
      checkOutput($sformatf("dnValid c%0d", c), outValidS[1], DnValid[c]);
      checkOutput($sformatf("dnAccept c%0d", c), inAcceptS[1], DnAcc[c]);
      if (DnValid[c]) checkOutput($sformatf("dnData c%0d", c), outDataS[1], DnData[c]);
    end

    // Rounding 20->8 through the output register.
    for (int c = 0; c < 7; c++) begin
      idleAll();
      if (c == 0) begin
        inValid[2] = 1'b1;
        setInData(2, 64'hABCDE);
      end
      tick();
      checkOutput($sformatf("rndValid c%0d", c), outValidS[2], RdValid[c]);
      if (RdValid[c]) checkOutput($sformatf("rndData c%0d", c), outDataS[2], RdData[c]);
    end

    // Backpressure mid-word on the 24->8 path.
    for (int c = 0; c < 10; c++) begin
      idleAll();
      if (c == 0) begin
        inValid[1] = 1'b1;
        setInData(1, 64'h123456);
      end
      if (c >= 2 && c <= 6) outReady[1] = 1'b0;
      tick();
      checkOutput($sformatf("bpValid c%0d", c), outValidS[1], BpValid[c]);
      if (BpValid[c]) checkOutput($sformatf("bpData c%0d", c), outDataS[1], BpData[c]);
      if (c >= 2 && c <= 6) checkOutput($sformatf("bpAccept c%0d", c), inAcceptS[1], 0);
    end

    // Reset after three upsize words discards them.
    for (int c = 0; c < 3; c++) begin
      idleAll();
      inValid[0] = 1'b1;
      setInData(0, 64'(50 + c));
      tick();
    end
    idleAll();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rstMidValid", outValidS[0], 0);
    checkOutput("rstMidAccept", inAcceptS[0], 1);
    pulses = 0;
    expWord = '0;
    for (int k = 0; k < 8; k++) expWord = expWord | (512'(100 + k) << (k * 64));
    for (int c = 0; c < 15; c++) begin
      idleAll();
      if (c < 8) begin
        inValid[0] = 1'b1;
        setInData(0, 64'(100 + c));
      end
      tick();
      if (outValidS[0]) begin
        pulses++;
        checkOutput("rstMidData", outDataS[0], expWord);
      end
    end
    checkOutput("rstMidPulses", pulses, 1);

    // Random traffic on every configuration until the 64->64 path has moved 1000 words.
    for (int i = 0; i < NI; i++) outCount[i] = 0;
    guard = 0;
    while (outCount[3] < 1000 && guard < 20000) begin
      for (int i = 0; i < NI; i++) applyStimulus(i);
      tick();
      guard++;
    end
    checkOutput("eqWords", (outCount[3] >= 1000), 1);
    idleAll();
    repeat (60) tick();
    for (int i = 0; i < NI; i++) checkOutput($sformatf("drain%0d", i), expQ[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
